max6682_spi_reader: RTL and testbench
=====================================

MAX6682_SPI_READER -- requirements
Module: max6682_spi_reader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the cycle budget for stWait/stRead1/stRead2; used only with the macro.
REQ-002 SHALL have ports as follows (one per line), first: Clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 Reset_i  in  1  reset, synchronous, active-high.
REQ-004 Start_i  in  1  request one 2-byte sensor read.
REQ-005 Busy_o  out  1  high in every state except stIdle.
REQ-006 Done_o  out  1  one-cycle pulse at end of read.
REQ-007 Error_o  out  1  one-cycle timeout pulse, coincident with Done_o.
REQ-008 MAX6682CS_n_o  out  1  sensor chip select, active-low.
REQ-009 SPI_Write_o / SPI_ReadNext_o  out  1 each  TX FIFO push / RX FIFO pop.
REQ-010 SPI_Data_o  out  8  TX byte; SHALL be constant 8'h00.
REQ-011 SPI_Data_i  in  8  RX FIFO head; SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i  in  1 each  SPI master status.
REQ-012 Byte0_o, Byte1_o  out  8 each  first/second received byte; Value_o  out  16  = {5'b0, Byte1_o, Byte0_o[7:5]}.

Function
REQ-013 States SHALL be stIdle, stWrite1, stWrite2, stWait, stRead1, stRead2, stDone.
REQ-014 stIdle: CS_n=1; on Start_i=1 SHALL go to stWrite1 next cycle; Start_i in any other state SHALL be ignored (no queuing).
REQ-015 stWrite1/stWrite2: CS_n=0; SPI_Write_o=1 only if SPI_FIFOFull_i=0, else SHALL stay in the state with SPI_Write_o=0; after the push, advance.
REQ-016 stWait: CS_n=0; SHALL set a seen flag when SPI_Transmission_i=1 and advance to stRead1 on the first cycle with seen=1 and SPI_Transmission_i=0; the flag SHALL clear on entry to stWrite1.
REQ-017 stRead1: if SPI_FIFOEmpty_i=0, SHALL latch Byte0_o<=SPI_Data_i, pulse SPI_ReadNext_o, advance; else SHALL hold.
REQ-018 stRead2: same as stRead1 for Byte1_o.
REQ-019 stDone: CS_n=1, Done_o=1 for exactly one cycle, then stIdle; Start_i seen in stDone SHALL be ignored.
REQ-020 Byte0_o/Byte1_o SHALL change only in stRead1/stRead2; Value_o SHALL be combinational from them.
REQ-021 SPI_Write_o and SPI_ReadNext_o SHALL never be high in the same cycle, nor outside their states.
REQ-022 Nominal latency: Start at cycle 0 with no back-pressure gives Done_o at cycle (first low-Transmission cycle after seen) + 3.

Reset
REQ-023 Reset_i SHALL force stIdle, clear the seen flag and timeout counter, and set Byte0_o=Byte1_o=0, CS_n=1, Busy_o=Done_o=Error_o=SPI_Write_o=SPI_ReadNext_o=0.
REQ-024 Reset_i mid-transfer SHALL take effect the next edge, deasserting CS_n with no Done_o pulse.

Configuration
REQ-025 Macro MAX6682_SPI_READER_TIMEOUT_EN defined: a counter SHALL load 0 on entry to stWait and increment in stWait/stRead1/stRead2; on reaching TIMEOUT_CYCLES-1 the FSM SHALL go to stDone with Error_o=1, and Byte0_o/Byte1_o SHALL keep their prior values unless already updated.
REQ-026 Macro undefined: no counter is built, Error_o SHALL be tied 0, and the FSM SHALL wait indefinitely.

Structure
REQ-027 Package max6682_spi_reader_pkg SHALL hold the state enum, the TX dummy-byte constant 8'h00 and the Value_o bit-layout constants (pad width 5, Byte0 slice 7:5).
REQ-028 SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-029 Start@0, Transmission high on cycles 4-19, FIFO bytes 8'h1A, 8'hE0: Done_o@23, Byte0_o=1A, Byte1_o=E0, Value_o=16'h0700.
REQ-030 FIFOFull_i=1 on cycles 1-5: SPI_Write_o first high @6, exactly two pushes total, CS_n low from cycle 1.
REQ-031 Start_i pulsed each cycle during a transfer: exactly one Done_o, pushes=2, pops=2.
REQ-032 FIFOEmpty_i=1 for 3 cycles in stRead1: hold with no pop, then capture the correct byte.
REQ-033 Reset_i@10 mid-stWait: CS_n=1 @11, Byte regs 0, no Done_o; a new Start then completes normally.
REQ-034 Macro on, TIMEOUT_CYCLES=16, Transmission never high: Error_o and Done_o together 16 cycles after stWait entry, CS_n=1, bytes unchanged; macro off: Busy_o stays high.

Source files
------------

// File: rtl/max6682_spi_reader_pkg.sv
// Shared definitions for the MAX6682 SPI reader.
//   - stateT and its st* constants: FSM state encoding
//   - TxDummyByte: byte pushed to the SPI TX FIFO to clock the sensor out
//   - ValuePadWidth/Byte0Msb/Byte0Lsb: layout of the assembled 16-bit Value_o
package max6682_spi_reader_pkg;

  // State encoding, kept as plain constants for compatibility with older tools.
  typedef logic [2:0] stateT;

  localparam stateT stIdle   = 3'd0;
  localparam stateT stWrite1 = 3'd1;
  localparam stateT stWrite2 = 3'd2;
  localparam stateT stWait   = 3'd3;
  localparam stateT stRead1  = 3'd4;
  localparam stateT stRead2  = 3'd5;
  localparam stateT stDone   = 3'd6;

  localparam logic [7:0] TxDummyByte = 8'h00;

  // Value_o = {pad zeros, Byte1, Byte0[Byte0Msb:Byte0Lsb]}
  localparam int unsigned ValuePadWidth = 5;
  localparam int unsigned Byte0Msb      = 7;
  localparam int unsigned Byte0Lsb      = 5;

endpackage

// File: rtl/max6682_spi_reader_if.sv
// Connection between the MAX6682 reader and an SPI master with TX/RX FIFOs.
// Signal names are seen from the reader's side.
//   SPI_Write_o        push SPI_Data_o into the TX FIFO
//   SPI_ReadNext_o     pop the RX FIFO head
//   SPI_Data_o         TX byte
//   SPI_Data_i         RX FIFO head
//   SPI_FIFOFull_i     TX FIFO full
//   SPI_FIFOEmpty_i    RX FIFO empty
//   SPI_Transmission_i SPI shift in progress
// Modports: master = reader, slave = SPI master.
interface max6682_spi_reader_if;

  logic       SPI_Write_o;
  logic       SPI_ReadNext_o;
  logic [7:0] SPI_Data_o;
  logic [7:0] SPI_Data_i;
  logic       SPI_FIFOFull_i;
  logic       SPI_FIFOEmpty_i;
  logic       SPI_Transmission_i;

  modport master (
    output SPI_Write_o,
    output SPI_ReadNext_o,
    output SPI_Data_o,
    input  SPI_Data_i,
    input  SPI_FIFOFull_i,
    input  SPI_FIFOEmpty_i,
    input  SPI_Transmission_i
  );

  modport slave (
    input  SPI_Write_o,
    input  SPI_ReadNext_o,
    input  SPI_Data_o,
    output SPI_Data_i,
    output SPI_FIFOFull_i,
    output SPI_FIFOEmpty_i,
    output SPI_Transmission_i
  );

endinterface

// File: rtl/max6682_spi_reader.sv
// Reads one 2-byte temperature sample from a MAX6682 through an SPI master.
// On Start_i it pushes two dummy bytes, waits for the shift to finish, pops the
// two received bytes and pulses Done_o.
// Ports:
//   Clk_i, Reset_i     clock, synchronous active-high reset
//   Start_i            request one read (ignored unless idle)
//   Busy_o             high whenever not idle
//   Done_o, Error_o    end-of-read pulse, timeout pulse (coincident with Done_o)
//   MAX6682CS_n_o      sensor chip select, active-low
//   Spi                SPI master FIFO/status connection (master modport)
//   Byte0_o, Byte1_o   first/second received byte
//   Value_o            {5'b0, Byte1_o, Byte0_o[7:5]}
// Build option: define MAX6682_SPI_READER_TIMEOUT_EN to abort a read that
// spends TIMEOUT_CYCLES cycles in stWait/stRead1/stRead2; otherwise the reader
// waits indefinitely and Error_o is tied low.
module max6682_spi_reader
  import max6682_spi_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        Clk_i,
  input  logic                        Reset_i,
  input  logic                        Start_i,
  output logic                        Busy_o,
  output logic                        Done_o,
  output logic                        Error_o,
  output logic                        MAX6682CS_n_o,
  max6682_spi_reader_if.master        Spi,
  output logic [7:0]                  Byte0_o,
  output logic [7:0]                  Byte1_o,
  output logic [15:0]                 Value_o
);

  stateT      stateQ, stateD;
  logic       seenQ, seenD;
  logic [7:0] byte0Q, byte0D;
  logic [7:0] byte1Q, byte1D;
  logic       spiWrite, spiReadNext, csN;

`ifdef MAX6682_SPI_READER_TIMEOUT_EN
  localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

  logic [CntWidth-1:0] cntQ, cntD;
  logic                errQ, errD;
`endif

  always_comb begin
    stateD      = stateQ;
    seenD       = seenQ;
    byte0D      = byte0Q;
    byte1D      = byte1Q;
    spiWrite    = 1'b0;
    spiReadNext = 1'b0;
    csN         = 1'b1;
`ifdef MAX6682_SPI_READER_TIMEOUT_EN
    cntD        = cntQ;
    errD        = 1'b0;
`endif

    case (stateQ)
      stIdle: begin
        if (Start_i) begin
          stateD = stWrite1;
          seenD  = 1'b0;
        end
      end
      stWrite1: begin
        csN = 1'b0;
        if (!Spi.SPI_FIFOFull_i) begin
          spiWrite = 1'b1;
          stateD   = stWrite2;
        end
      end
      stWrite2: begin
        csN = 1'b0;
        if (!Spi.SPI_FIFOFull_i) begin
          spiWrite = 1'b1;
          stateD   = stWait;
`ifdef MAX6682_SPI_READER_TIMEOUT_EN
          cntD     = '0;
`endif
        end
      end
      stWait: begin
        csN = 1'b0;
        // Only a falling Transmission after it was seen high marks the end
        // of the shift; a low level before the shift starts is ignored.
        if (Spi.SPI_Transmission_i) begin
          seenD = 1'b1;
        end else if (seenQ) begin
          stateD = stRead1;
        end
      end
      stRead1: begin
        csN = 1'b0;
        if (!Spi.SPI_FIFOEmpty_i) begin
          byte0D      = Spi.SPI_Data_i;
          spiReadNext = 1'b1;
          stateD      = stRead2;
        end
      end
      stRead2: begin
        csN = 1'b0;
        if (!Spi.SPI_FIFOEmpty_i) begin
          byte1D      = Spi.SPI_Data_i;
          spiReadNext = 1'b1;
          stateD      = stDone;
        end
      end
      stDone: begin
        stateD = stIdle;
      end
      default: begin
        stateD = stIdle;
      end
    endcase

`ifdef MAX6682_SPI_READER_TIMEOUT_EN
    // Timeout wins over a same-cycle read so a late byte is not half-consumed.
    if ((stateQ == stWait) || (stateQ == stRead1) || (stateQ == stRead2)) begin
      if (cntQ == CntLast) begin
        stateD      = stDone;
        errD        = 1'b1;
        byte0D      = byte0Q;
        byte1D      = byte1Q;
        spiReadNext = 1'b0;
      end else begin
        cntD = cntQ + CntWidth'(1);
      end
    end
`endif
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      stateQ <= stIdle;
      seenQ  <= 1'b0;
      byte0Q <= 8'h00;
      byte1Q <= 8'h00;
    end else begin
      stateQ <= stateD;
      seenQ  <= seenD;
      byte0Q <= byte0D;
      byte1Q <= byte1D;
    end
  end

`ifdef MAX6682_SPI_READER_TIMEOUT_EN
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      cntQ <= '0;
      errQ <= 1'b0;
    end else begin
      cntQ <= cntD;
      errQ <= errD;
    end
  end

  // errQ is only ever set on the transition into stDone.
  assign Error_o = errQ;
`else
  assign Error_o = 1'b0;
`endif

  assign Busy_o             = (stateQ != stIdle);
  assign Done_o             = (stateQ == stDone);
  assign MAX6682CS_n_o      = csN;
  assign Spi.SPI_Write_o    = spiWrite;
  assign Spi.SPI_ReadNext_o = spiReadNext;
  assign Spi.SPI_Data_o     = TxDummyByte;
  assign Byte0_o            = byte0Q;
  assign Byte1_o            = byte1Q;
  assign Value_o            = {{ValuePadWidth{1'b0}}, byte1Q, byte0Q[Byte0Msb:Byte0Lsb]};

endmodule

// File: tb/tb_max6682_spi_reader.sv
// Scoreboard bench for max6682_spi_reader: each directed transfer pushes its
// hand-computed result into a queue and a negedge monitor compares it when
// Done_o pulses.
module tb_max6682_spi_reader;

  logic        Clk_i = 1'b0;
  logic        Reset_i;
  logic        Start_i;
  logic        Busy_o, Done_o, Error_o, MAX6682CS_n_o;
  logic [7:0]  Byte0_o, Byte1_o;
  logic [15:0] Value_o;

  max6682_spi_reader_if spiIf ();

  max6682_spi_reader #(
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .Clk_i         (Clk_i),
    .Reset_i       (Reset_i),
    .Start_i       (Start_i),
    .Busy_o        (Busy_o),
    .Done_o        (Done_o),
    .Error_o       (Error_o),
    .MAX6682CS_n_o (MAX6682CS_n_o),
    .Spi           (spiIf.master),
    .Byte0_o       (Byte0_o),
    .Byte1_o       (Byte1_o),
    .Value_o       (Value_o)
  );

`ifdef MAX6682_SPI_READER_TIMEOUT_EN
  // Short-timeout copy, started only during the timeout scenario.
  logic        tPhase = 1'b0;
  logic        tStart, tBusy, tDone, tErr, tCsN;
  logic [7:0]  tByte0, tByte1;
  logic [15:0] tValue;
  max6682_spi_reader_if spiIfT ();
  assign tStart                    = Start_i & tPhase;
  assign spiIfT.SPI_Data_i         = spiIf.SPI_Data_i;
  assign spiIfT.SPI_FIFOFull_i     = spiIf.SPI_FIFOFull_i;
  assign spiIfT.SPI_FIFOEmpty_i    = spiIf.SPI_FIFOEmpty_i;
  assign spiIfT.SPI_Transmission_i = spiIf.SPI_Transmission_i;

  max6682_spi_reader #(
    .TIMEOUT_CYCLES(16)
  ) dutT (
    .Clk_i         (Clk_i),
    .Reset_i       (Reset_i),
    .Start_i       (tStart),
    .Busy_o        (tBusy),
    .Done_o        (tDone),
    .Error_o       (tErr),
    .MAX6682CS_n_o (tCsN),
    .Spi           (spiIfT.master),
    .Byte0_o       (tByte0),
    .Byte1_o       (tByte1),
    .Value_o       (tValue)
  );
`endif

  always #5 Clk_i = ~Clk_i;

  int cyc = 0;
  always @(posedge Clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] val;
    logic        err;
    int          cycle;
  } expT;

  expT expQ[$];
  int  nChecks = 0;
  int  nPass = 0;
  int  doneCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: pops one expectation per Done_o pulse.
  expT e;
  always @(negedge Clk_i) begin
    if (spiIf.SPI_Write_o && spiIf.SPI_ReadNext_o)
      check("push_pop_same_cycle", {31'b0, spiIf.SPI_ReadNext_o}, 32'd0);
    if (Error_o && !Done_o) check("error_without_done", {31'b0, Error_o}, 32'd0);
    if (Done_o) begin
      doneCount++;
      if (expQ.size() == 0) begin
        check("unexpected_done", {31'b0, Done_o}, 32'd0);
      end else begin
        e = expQ.pop_front();
        check("done_cycle", cyc, e.cycle);
        check("byte0", {24'b0, Byte0_o}, {24'b0, e.b0});
        check("byte1", {24'b0, Byte1_o}, {24'b0, e.b1});
        check("value", {16'b0, Value_o}, {16'b0, e.val});
        check("error", {31'b0, Error_o}, {31'b0, e.err});
      end
    end
  end

  // Per-transfer observations.
  int   pushes, pops, firstW, holdPops;
  logic csAt1, csAfterRst, busyAfterRst;
  logic [7:0] b0AfterRst, b1AfterRst;
  int   tDoneAt, tErrAt;
  logic tCsAtDone;

  // One transfer from the caller's current cycle (k = 0 carries Start_i).
  // Ranges [s,e] with s > e are empty. Bytes enter the RX FIFO at k == tE.
  task automatic runXfer(
    input bit pulseStart, input int tS, input int tE, input int fS, input int fE,
    input int eS, input int eE, input int rstAt, input int nCyc,
    input logic [7:0] b0, input logic [7:0] b1,
    input int expDoneRel, input logic expErr, input logic [7:0] expB0,
    input logic [7:0] expB1, input logic [15:0] expVal);
    logic [7:0] rxQ[$];
    expT x;
    pushes = 0; pops = 0; firstW = -1; holdPops = 0;
    tDoneAt = -1; tErrAt = -1; tCsAtDone = 1'b0;
    if (expDoneRel >= 0) begin
      x.b0 = expB0; x.b1 = expB1; x.val = expVal; x.err = expErr;
      x.cycle = cyc + expDoneRel;
      expQ.push_back(x);
    end
    for (int k = 0; k < nCyc; k++) begin
      Start_i = (k == 0) || (pulseStart && k <= 23);
      Reset_i = (k == rstAt);
      spiIf.SPI_Transmission_i = (k >= tS && k <= tE);
      spiIf.SPI_FIFOFull_i     = (k >= fS && k <= fE);
      if (k == tE) begin
        rxQ.push_back(b0);
        rxQ.push_back(b1);
      end
      spiIf.SPI_FIFOEmpty_i = (rxQ.size() == 0) || (k >= eS && k <= eE);
      spiIf.SPI_Data_i      = (rxQ.size() != 0) ? rxQ[0] : 8'h00;
      #1;
      if (k == 1) csAt1 = MAX6682CS_n_o;
      if (k == rstAt + 1) begin
        csAfterRst = MAX6682CS_n_o; busyAfterRst = Busy_o;
        b0AfterRst = Byte0_o; b1AfterRst = Byte1_o;
      end
      if (spiIf.SPI_Write_o) begin
        pushes++;
        if (firstW < 0) firstW = k;
      end
      if (spiIf.SPI_ReadNext_o) begin
        pops++;
        if (k >= eS && k <= eE) holdPops++;
        if (rxQ.size() != 0) void'(rxQ.pop_front());
      end
`ifdef MAX6682_SPI_READER_TIMEOUT_EN
      if (tDone && tDoneAt < 0) begin
        tDoneAt = k;
        tCsAtDone = tCsN;
      end
      if (tErr && tErrAt < 0) tErrAt = k;
`endif
      @(posedge Clk_i);
      #1;
    end
    Start_i = 1'b0;
    Reset_i = 1'b0;
    spiIf.SPI_Transmission_i = 1'b0;
    spiIf.SPI_FIFOFull_i     = 1'b0;
    spiIf.SPI_FIFOEmpty_i    = 1'b1;
  endtask

  int dc0;

  initial begin
    Reset_i = 1'b1;
    Start_i = 1'b0;
    spiIf.SPI_Transmission_i = 1'b0;
    spiIf.SPI_FIFOFull_i     = 1'b0;
    spiIf.SPI_FIFOEmpty_i    = 1'b1;
    spiIf.SPI_Data_i         = 8'h00;
    repeat (3) @(posedge Clk_i);
    #1;
    check("rst_cs_n",     {31'b0, MAX6682CS_n_o}, 32'd1);
    check("rst_busy",     {31'b0, Busy_o}, 32'd0);
    check("rst_done",     {31'b0, Done_o}, 32'd0);
    check("rst_error",    {31'b0, Error_o}, 32'd0);
    check("rst_write",    {31'b0, spiIf.SPI_Write_o}, 32'd0);
    check("rst_readnext", {31'b0, spiIf.SPI_ReadNext_o}, 32'd0);
    check("rst_byte0",    {24'b0, Byte0_o}, 32'd0);
    check("rst_byte1",    {24'b0, Byte1_o}, 32'd0);
    check("tx_byte",      {24'b0, spiIf.SPI_Data_o}, 32'd0);
    Reset_i = 1'b0;
    @(posedge Clk_i);
    #1;

    // Nominal read: Transmission 4..19, Done at 23.
    runXfer(0, 4, 19, -1, -2, -1, -2, -1, 28, 8'h1A, 8'hE0, 23, 1'b0, 8'h1A, 8'hE0, 16'h0700);
    check("nom_cs_low_at_1", {31'b0, csAt1}, 32'd0);
    check("nom_pushes", pushes, 2);
    check("nom_pops", pops, 2);

    // TX FIFO full on cycles 1..5.
    runXfer(0, 9, 24, 1, 5, -1, -2, -1, 32, 8'h55, 8'hAA, 28, 1'b0, 8'h55, 8'hAA, 16'h0552);
    check("full_first_write", firstW, 6);
    check("full_pushes", pushes, 2);
    check("full_pops", pops, 2);
    check("full_cs_low_at_1", {31'b0, csAt1}, 32'd0);

    // Start_i held every cycle through stDone: only one read.
    dc0 = doneCount;
    runXfer(1, 4, 19, -1, -2, -1, -2, -1, 30, 8'h3C, 8'h81, 23, 1'b0, 8'h3C, 8'h81, 16'h0409);
    check("pulse_done_count", doneCount - dc0, 1);
    check("pulse_pushes", pushes, 2);
    check("pulse_pops", pops, 2);

    // RX FIFO empty for 3 cycles in stRead1.
    runXfer(0, 4, 19, -1, -2, 21, 23, -1, 30, 8'hFF, 8'h12, 26, 1'b0, 8'hFF, 8'h12, 16'h0097);
    check("empty_hold_pops", holdPops, 0);
    check("empty_pops", pops, 2);

    // Reset at cycle 10 during stWait.
    dc0 = doneCount;
    runXfer(0, 4, 19, -1, -2, -1, -2, 10, 24, 8'h77, 8'h66, -1, 1'b0, 8'h00, 8'h00, 16'h0000);
    check("rst_mid_cs_n", {31'b0, csAfterRst}, 32'd1);
    check("rst_mid_busy", {31'b0, busyAfterRst}, 32'd0);
    check("rst_mid_byte0", {24'b0, b0AfterRst}, 32'd0);
    check("rst_mid_byte1", {24'b0, b1AfterRst}, 32'd0);
    check("rst_mid_no_done", doneCount - dc0, 0);
    runXfer(0, 4, 19, -1, -2, -1, -2, -1, 28, 8'h9C, 8'h47, 23, 1'b0, 8'h9C, 8'h47, 16'h023C);
    check("after_rst_pops", pops, 2);

    // Transmission never rises.
`ifdef MAX6682_SPI_READER_TIMEOUT_EN
    tPhase = 1'b1;
`endif
    runXfer(0, -1, -2, -1, -2, -1, -2, -1, 40, 8'h00, 8'h00, -1, 1'b0, 8'h00, 8'h00, 16'h0000);
    check("stuck_busy", {31'b0, Busy_o}, 32'd1);
    check("stuck_pops", pops, 0);
`ifdef MAX6682_SPI_READER_TIMEOUT_EN
    tPhase = 1'b0;
    check("tmo_done_at", tDoneAt, 19);
    check("tmo_error_at", tErrAt, 19);
    check("tmo_cs_n", {31'b0, tCsAtDone}, 32'd1);
    check("tmo_byte0", {24'b0, tByte0}, 32'd0);
    check("tmo_byte1", {24'b0, tByte1}, 32'd0);
`endif
    Reset_i = 1'b1;
    @(posedge Clk_i);
    #1;
    Reset_i = 1'b0;
    check("stuck_rst_busy", {31'b0, Busy_o}, 32'd0);
    repeat (3) @(posedge Clk_i);
    #1;

    check("pending_expectations", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
